// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO controller and its
// output buffer.
package fifo_pkg;

    localparam int OB_DEPTH   = 2;
    localparam int OB_CW      = $clog2(OB_DEPTH + 1);
    localparam int AF_OFFSET  = 2;
    localparam int AE_DEFAULT = 2;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_sync_ctrl_if.sv
// Push stream, pop stream and external RAM port bundle of the FIFO controller.
// slave is the controller's view; master is the producer/consumer/RAM side.
interface fifo_sync_ctrl_if #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
);
    import fifo_pkg::*;

    localparam int AW = addr_w(DEPTH);

    logic             wr_valid;
    logic             wr_ready;
    logic [WIDTH-1:0] wr_data;

    logic             rd_valid;
    logic             rd_ready;
    logic [WIDTH-1:0] rd_data;

    logic             mem_write_en;
    logic [AW-1:0]    mem_write_addr;
    logic [WIDTH-1:0] mem_data_in;
    logic             mem_read_en;
    logic [AW-1:0]    mem_read_addr;
    logic [WIDTH-1:0] mem_data_out;
    logic             mem_data_out_vld;

    modport slave (
        input  wr_valid, wr_data, rd_ready, mem_data_out, mem_data_out_vld,
        output wr_ready, rd_valid, rd_data,
        output mem_write_en, mem_write_addr, mem_data_in, mem_read_en, mem_read_addr
    );

    modport master (
        output wr_valid, wr_data, rd_ready, mem_data_out, mem_data_out_vld,
        input  wr_ready, rd_valid, rd_data,
        input  mem_write_en, mem_write_addr, mem_data_in, mem_read_en, mem_read_addr
    );

endinterface

// File: rtl/fifo_out_buf.sv
// Two-entry registered first-word-fall-through buffer fed by RAM read data.
// Capture and pop may happen in the same cycle; the head is always a register.
module fifo_out_buf
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cap_en,
    input  logic [WIDTH-1:0] cap_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [OB_CW-1:0] ob_cnt
);

    logic [OB_CW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
    logic             do_pop;

    always_comb begin
        cnt_d  = cnt_q;
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        do_pop = pop && (cnt_q != '0);
        case ({cap_en, do_pop})
            2'b11: begin
                if (cnt_q == OB_CW'(1)) begin
                    ent0_d = cap_data;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = cap_data;
                end
            end
            2'b01: begin
                ent0_d = ent1_q;
                cnt_d  = cnt_q - OB_CW'(1);
            end
            2'b10: begin
                if (cnt_q == '0) ent0_d = cap_data;
                else             ent1_d = cap_data;
                cnt_d = cnt_q + OB_CW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // NOTE: data registers carry no reset; validity is tracked solely by cnt_q.
    always_ff @(posedge clk) begin
        ent0_q <= ent0_d;
        ent1_q <= ent1_d;
    end

    assign head   = ent0_q;
    assign ob_cnt = cnt_q;

endmodule

// File: rtl/fifo_sync_ctrl.sv
// Single-clock FIFO controller: owns RAM pointers, prefetches through a 1-cycle
// registered RAM read into a 2-entry FWFT buffer, and tracks total occupancy.
module fifo_sync_ctrl
    import fifo_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int WIDTH    = 8,
    parameter int AF_LEVEL = DEPTH - AF_OFFSET,
    parameter int AE_LEVEL = AE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fifo_sync_ctrl_if.slave       bus,
    output logic [addr_w(DEPTH):0] count,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow
);

    localparam int AW = addr_w(DEPTH);
    typedef logic [AW:0] ptr_t;

    localparam ptr_t DEPTH_C = ptr_t'(DEPTH);
    localparam ptr_t AF_C    = ptr_t'(AF_LEVEL);
    localparam ptr_t AE_C    = ptr_t'(AE_LEVEL);

    ptr_t wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d, mem_cnt;
    logic inflight_q, inflight_d, overflow_q, overflow_d;
    logic wr_ready, rd_valid, push, pop, rd_issue, cap_en;
    logic [OB_CW-1:0] ob_cnt;
    logic [OB_CW:0]   ob_occ;
    logic [WIDTH-1:0] head;

    always_comb begin
        // NOTE: every signal is assigned on every pass, so no latches can be inferred.
        wr_ready   = rst_n && (count_q < DEPTH_C);
        rd_valid   = (ob_cnt != '0);
        push       = bus.wr_valid && wr_ready;
        pop        = rd_valid && bus.rd_ready;
        mem_cnt    = wptr_q - rptr_q;
        // Buffer slots already spoken for after this cycle's pop.
        ob_occ     = {1'b0, ob_cnt} + (OB_CW + 1)'(inflight_q) - (OB_CW + 1)'(pop);
        rd_issue   = (mem_cnt != '0) && (ob_occ < (OB_CW + 1)'(OB_DEPTH));
        cap_en     = inflight_q && bus.mem_data_out_vld;
        wptr_d     = wptr_q + ptr_t'(push);
        rptr_d     = rptr_q + ptr_t'(rd_issue);
        count_d    = count_q + ptr_t'(push) - ptr_t'(pop);
        inflight_d = rd_issue;
        overflow_d = overflow_q || (bus.wr_valid && !wr_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state flops use non-blocking assignment so all update together at the edge.
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            overflow_q <= overflow_d;
        end
    end

    fifo_out_buf #(.WIDTH(WIDTH)) u_out_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .cap_en   (cap_en),
        .cap_data (bus.mem_data_out),
        .pop      (pop),
        .head     (head),
        .ob_cnt   (ob_cnt)
    );

    assign bus.wr_ready       = wr_ready;
    assign bus.mem_write_en   = push;
    assign bus.mem_write_addr = wptr_q[AW-1:0];
    assign bus.mem_data_in    = bus.wr_data;
    assign bus.mem_read_en    = rd_issue;
    assign bus.mem_read_addr  = rptr_q[AW-1:0];
    assign bus.rd_valid       = rd_valid;
    assign bus.rd_data        = head;

    assign count        = count_q;
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Directed bench for fifo_sync_ctrl with a behavioural 1-cycle RAM and a
// scoreboard monitor checking output order, count and flags every cycle.
module tb_fifo_sync_ctrl;
    import fifo_pkg::*;

    localparam int DEPTH = 8;
    localparam int WIDTH = 8;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       inject = 1'b0;
    logic [3:0] count;
    logic       almost_full, almost_empty, overflow;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp_q[$];
    int   mcount;
    bit   movf;

    fifo_sync_ctrl_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    fifo_sync_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    // RAM model: registered read, vld one cycle after read enable; inject
    // produces a stray vld with junk data when no read was issued.
    logic [WIDTH-1:0] ram [DEPTH];
    logic rvld_q, inj_q;
    always @(posedge clk) begin
        if (bus.mem_write_en) ram[bus.mem_write_addr] <= bus.mem_data_in;
        rvld_q <= bus.mem_read_en;
        inj_q  <= inject && !bus.mem_read_en;
        if (bus.mem_read_en) bus.mem_data_out <= ram[bus.mem_read_addr];
        else if (inject)     bus.mem_data_out <= 8'hEE;
    end
    assign bus.mem_data_out_vld = rvld_q | inj_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        bus.rd_ready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
        check({name, "_empty_q"}, 32'(exp_q.size()), 0);
        check({name, "_count0"}, 32'(count), 0);
        check({name, "_rd_valid0"}, 32'(bus.rd_valid), 0);
    endtask

    // Scoreboard monitor: samples on the falling edge what the next rising
    // edge will do; pushes accepted data, pops and compares on each output.
    initial begin
        logic acc, popped;
        logic [WIDTH-1:0] want;
        mcount = 0;
        movf   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                mcount = 0;
                movf   = 1'b0;
                check("rst_wr_ready", 32'(bus.wr_ready), 0);
                check("rst_count", 32'(count), 0);
                check("rst_mem_write_en", 32'(bus.mem_write_en), 0);
            end else begin
                acc = (mcount < DEPTH);
                check("count", 32'(count), 32'(mcount));
                check("wr_ready", 32'(bus.wr_ready), 32'(acc));
                check("almost_full", 32'(almost_full), 32'(mcount >= DEPTH - 2));
                check("almost_empty", 32'(almost_empty), 32'(mcount <= 2));
                check("overflow", 32'(overflow), 32'(movf));
                popped = bus.rd_valid && bus.rd_ready;
                if (popped) begin
                    check("pop_nonempty", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        want = exp_q.pop_front();
                        check("rd_data", 32'(bus.rd_data), 32'(want));
                    end
                end
                if (bus.wr_valid && acc)  exp_q.push_back(bus.wr_data);
                if (bus.wr_valid && !acc) movf = 1'b1;
                mcount = mcount + int'(bus.wr_valid && acc) - int'(popped);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int   n_out;
        int   sent;
        int   guard;
        logic acc_w;

        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'h55;
        bus.rd_ready = 1'b0;

        // Reset held with a pending push request.
        repeat (2) @(posedge clk);
        #1;
        check("reset_wr_ready", 32'(bus.wr_ready), 0);
        check("reset_mem_write_en", 32'(bus.mem_write_en), 0);
        check("reset_count", 32'(count), 0);
        check("reset_almost_empty", 32'(almost_empty), 1);
        check("reset_almost_full", 32'(almost_full), 0);
        check("reset_rd_valid", 32'(bus.rd_valid), 0);
        check("reset_overflow", 32'(overflow), 0);
        bus.wr_valid = 1'b0;
        rst_n        = 1'b1;
        #1;
        check("release_wr_ready", 32'(bus.wr_ready), 1);

        // Single push: visible two edges later, for one cycle.
        step();
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'hA5;
        bus.rd_ready = 1'b1;
        step();
        bus.wr_valid = 1'b0;
        check("single_count_k", 32'(count), 1);
        check("single_valid_k", 32'(bus.rd_valid), 0);
        step();
        check("single_valid_k1", 32'(bus.rd_valid), 0);
        step();
        check("single_valid_k2", 32'(bus.rd_valid), 1);
        check("single_data_k2", 32'(bus.rd_data), 32'h A5);
        check("single_count_k2", 32'(count), 1);
        step();
        check("single_valid_k3", 32'(bus.rd_valid), 0);
        check("single_count_k3", 32'(count), 0);

        // Fill to full with the consumer stalled, then overflow attempt.
        bus.rd_ready = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 8'(i);
            step();
            check("fill_count", 32'(count), 32'(i));
            check("fill_almost_full", 32'(almost_full), 32'(i >= 6));
        end
        check("full_wr_ready", 32'(bus.wr_ready), 0);
        check("full_overflow_clear", 32'(overflow), 0);
        bus.wr_data = 8'h09;
        step();
        bus.wr_valid = 1'b0;
        check("overflow_set", 32'(overflow), 1);
        check("overflow_count", 32'(count), 8);
        check("full_head", 32'(bus.rd_data), 32'h01);
        bus.rd_ready = 1'b1;
        step();
        check("full_pop_wr_ready", 32'(bus.wr_ready), 1);
        check("full_pop_count", 32'(count), 7);
        drain("fill_drain");
        check("overflow_sticky", 32'(overflow), 1);

        // Streaming: one push and one pop per cycle once the pipe is primed.
        n_out = 0;
        bus.rd_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 8'h40 + 8'(i);
            step();
            if (bus.rd_valid) n_out++;
            if (i == 10) check("stream_count_steady", 32'(count), 3);
        end
        bus.wr_valid = 1'b0;
        check("stream_outputs", 32'(n_out), 30);
        drain("stream_drain");

        // Random back-pressure with stray RAM valid strobes.
        sent  = 0;
        guard = 0;
        while (sent < 200 && guard < 5000) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = sent[7:0] ^ 8'h5A;
            bus.rd_ready = 1'($urandom_range(0, 1));
            inject       = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            acc_w = bus.wr_ready;
            step();
            if (acc_w) sent++;
            guard++;
        end
        bus.wr_valid = 1'b0;
        inject       = 1'b0;
        check("random_sent", 32'(sent), 200);
        drain("random_drain");

        // Reset with five entries stored discards everything.
        bus.rd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 8'h71 + 8'(i);
            step();
        end
        bus.wr_valid = 1'b0;
        check("pre_reset_count", 32'(count), 5);
        check("pre_reset_valid", 32'(bus.rd_valid), 1);
        rst_n = 1'b0;
        #1;
        check("midreset_rd_valid", 32'(bus.rd_valid), 0);
        check("midreset_count", 32'(count), 0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        check("post_reset_wr_ready", 32'(bus.wr_ready), 1);
        step();
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'h3C;
        step();
        bus.wr_valid = 1'b0;
        for (int i = 0; i < 10 && !bus.rd_valid; i++) step();
        check("post_reset_valid", 32'(bus.rd_valid), 1);
        check("post_reset_first", 32'(bus.rd_data), 32'h3C);
        bus.rd_ready = 1'b1;
        drain("post_reset_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_sync_ctrl.md
Name: fifo_sync_ctrl

Overview:
- Single-clock FIFO controller that owns the pointers for the team's FIFO storage RAM. That RAM has a registered read with 1-cycle latency and a read-valid strobe.
- Accepts a push stream and drives the RAM write and read ports.
- Prefetches into a 2-entry output buffer and presents first-word-fall-through valid/ready data to the consumer.
- Sits between a producer and a CNN datapath stage. Both RAM clocks are tied to clk.

Parameters:
- DEPTH, 8, RAM entries and total FIFO capacity; power of two, at least 2.
- WIDTH, 8, data width in bits.
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  producer offers wr_data.
- wr_data  in  WIDTH  push data.
- wr_ready  out  1  push accepted this cycle when wr_valid=1.
- mem_write_en  out  1  RAM write enable.
- mem_write_addr  out  $clog2(DEPTH)  RAM write address.
- mem_data_in  out  WIDTH  RAM write data (= wr_data).
- mem_read_en  out  1  RAM read enable.
- mem_read_addr  out  $clog2(DEPTH)  RAM read address.
- mem_data_out  in  WIDTH  RAM registered read data.
- mem_data_out_vld  in  1  RAM read-data valid, one cycle after mem_read_en.
- rd_valid  out  1  head entry valid.
- rd_data  out  WIDTH  head entry.
- rd_ready  in  1  consumer pops when rd_valid=1.
- count  out  $clog2(DEPTH)+1  total occupancy: RAM + in-flight read + output buffer.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- overflow  out  1  sticky: a push was attempted while wr_ready=0.

Behaviour:
- Reset: clk is the only clock; rst_n is asynchronous, active-low.
  - While rst_n=0: wptr=rptr=0, inflight=0, buffer empty, count=0, rd_valid=0, wr_ready=0, overflow=0, mem_write_en=0, mem_read_en=0, almost_full=0, almost_empty=1.
  - rst_n must be held low across at least one clk edge. RAM contents are not cleared.
  - Reset mid-operation discards all stored, in-flight and buffered data.
- Pointers: wptr and rptr are $clog2(DEPTH)+1 bits and wrap naturally. RAM addresses are the low bits. mem_cnt = wptr - rptr.
- Push:
  - wr_ready = rst_n && (count < DEPTH), combinational from registers only.
  - push = wr_valid && wr_ready. It drives mem_write_en=1 and mem_write_addr=wptr[low] in the same cycle, and wptr increments.
- Overflow: wr_valid && !wr_ready sets overflow at the next edge. The push is dropped. Only reset clears overflow.
- Prefetch:
  - mem_read_en = (mem_cnt != 0) && (ob_cnt + inflight - pop < 2), where pop = rd_valid && rd_ready.
  - mem_read_addr = rptr[low]. rptr increments on each read issue. inflight <= mem_read_en.
- Capture:
  - When inflight && mem_data_out_vld, mem_data_out enters the buffer tail at the next edge.
  - mem_data_out_vld without inflight is ignored.
  - The buffer may capture and pop in the same cycle.
- Output:
  - rd_valid = ob_cnt != 0; rd_data is the buffer head register. No combinational path from mem_data_out to rd_data.
  - rd_ready while rd_valid=0 is ignored and has no effect.
- count:
  - Register, count <= count + push - pop. Simultaneous push and pop leave it unchanged.
  - Invariant: count = mem_cnt + inflight + ob_cnt, never above DEPTH.
- Latency: a push at edge k into an empty FIFO gives rd_valid=1 after edge k+2.
- Collisions: a same-cycle RAM write and read never target the same address, because reads require registered mem_cnt != 0.
- Full: with count=DEPTH, a pop at edge k gives wr_ready=1 in the cycle after edge k.

Decomposition:
- Shared package fifo_pkg holds:
  - the pointer-width helper, AW = $clog2(DEPTH);
  - default AF_LEVEL and AE_LEVEL offsets;
  - the output-buffer depth constant, OB_DEPTH = 2.
- One sub-module: fifo_out_buf, a 2-entry registered FWFT buffer with ports cap_en, cap_data, pop, head, ob_cnt.
- Pointer, count and flag logic stay in fifo_sync_ctrl. The RAM is external; the integration top wires it up.

Test Plan:
- Reset with wr_valid=1 held -> wr_ready=0, no mem_write_en, count=0, almost_empty=1; after release, wr_ready=1.
- Single push 0xA5 at edge k, rd_ready=1 -> rd_valid=1 with rd_data=0xA5 after edge k+2, one cycle only; count goes 1 then 0.
- DEPTH=8, 8 pushes 0x01..0x08 with rd_ready=0 -> wr_ready=0 and count=8; almost_full from count 6; a 9th wr_valid sets overflow; draining gives 0x01..0x08 in order.
- Continuous push and pop, rd_ready=1 for 32 cycles with an incrementing pattern -> after the first output, one item per cycle in order; count steady; RAM addresses wrap 7->0 without loss.
- Random rd_ready back-pressure over 200 pushes -> output order matches a scoreboard; count always equals the model; no capture when inflight=0.
- Assert rst_n mid-stream with 5 entries stored -> rd_valid=0 and count=0 immediately; after release, the first new push 0x3C is the first item read.
